// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns the byte stream from a PS/2 keyboard receiver into one event per key
// action. E0, F0 and E1 prefixes are stripped, and the result is reported as
// a scan code plus extended and release flags. A small bank of "held" bits
// tracks Space, Enter, Up and Down.
//
// Parameters
//   TIMEOUT_CYCLES   clocks a partial sequence may sit idle before it is
//                    dropped (2 .. 2^22-1)
// Ports
//   CLOCK_50         system clock, rising edge
//   reset            synchronous, active-high
//   received_data    byte from the PS/2 receiver
//   received_data_en one-cycle strobe qualifying received_data
//   key_code         scan code of the last completed event
//   key_extended     last event carried an E0 prefix
//   key_break        last event was a release
//   key_valid        one-cycle pulse when the key_* outputs update
//   key_held         {Down, Up, Enter, Space} pressed state
// Build option
//   TYPEMATIC_FILTER_EN  when defined, auto-repeat makes of an already held
//                        tracked key produce no event
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_break,
    output logic       key_valid,
    output logic [3:0] key_held
);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    localparam logic [21:0] TMO_LAST_C = 22'(TIMEOUT_CYCLES - 1);

    state_t      state_r, next_state_s;
    logic [2:0]  pause_cnt_r, pause_cnt_nxt_s;
    logic [21:0] tmo_cnt_r, tmo_cnt_nxt_s;
    logic [7:0]  key_code_r;
    logic        key_extended_r, key_break_r, key_valid_r;
    logic [3:0]  key_held_r;
    logic        emit_s, ev_ext_s, ev_brk_s, clr_held_s, suppress_s, valid_s;
    logic [7:0]  ev_code_s;
    logic [3:0]  ev_mask_s;

    // Maps a decoded event to its key_held bit; untracked keys give zero.
    function automatic logic [3:0] key_mask(input logic ext, input logic [7:0] code);
        logic [3:0] m;
        case ({ext, code})
            {1'b0, 8'h29}: m = 4'b0001;
            {1'b0, 8'h5A}: m = 4'b0010;
            {1'b1, 8'h75}: m = 4'b0100;
            {1'b1, 8'h72}: m = 4'b1000;
            default:       m = 4'b0000;
        endcase
        return m;
    endfunction

    // Prefix parser, Pause-sequence counter and idle timeout.
    always_comb begin
        next_state_s    = state_r;
        pause_cnt_nxt_s = pause_cnt_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;
        emit_s          = 1'b0;
        ev_code_s       = received_data;
        ev_ext_s        = 1'b0;
        ev_brk_s        = 1'b0;
        clr_held_s      = 1'b0;
        if (received_data_en) begin
            tmo_cnt_nxt_s = 22'd0;
            if (received_data == 8'hAA) begin
                // Keyboard self-test pass: it was reset, so nothing is held.
                next_state_s    = IDLE;
                pause_cnt_nxt_s = 3'd0;
                clr_held_s      = 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        case (received_data)
                            8'hE0: next_state_s = EXT;
                            8'hF0: next_state_s = BRK;
                            8'hE1: begin
                                next_state_s    = PAUSE;
                                pause_cnt_nxt_s = 3'd0;
                            end
                            8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: next_state_s = IDLE;
                            default: emit_s = 1'b1;
                        endcase
                    end
                    EXT: begin
                        if (received_data == 8'hF0) begin
                            next_state_s = EXT_BRK;
                        end else begin
                            emit_s       = 1'b1;
                            ev_ext_s     = 1'b1;
                            next_state_s = IDLE;
                        end
                    end
                    BRK: begin
                        if (received_data == 8'hF0) begin
                            next_state_s = BRK;
                        end else if (received_data == 8'hE0) begin
                            next_state_s = EXT_BRK;
                        end else begin
                            emit_s       = 1'b1;
                            ev_brk_s     = 1'b1;
                            next_state_s = IDLE;
                        end
                    end
                    EXT_BRK: begin
                        if (received_data == 8'hF0) begin
                            next_state_s = EXT_BRK;
                        end else begin
                            emit_s       = 1'b1;
                            ev_ext_s     = 1'b1;
                            ev_brk_s     = 1'b1;
                            next_state_s = IDLE;
                        end
                    end
                    PAUSE: begin
                        // The Pause key sends E1 plus seven opaque bytes.
                        if (pause_cnt_r == 3'd6) begin
                            emit_s          = 1'b1;
                            ev_code_s       = 8'hE1;
                            pause_cnt_nxt_s = 3'd0;
                            next_state_s    = IDLE;
                        end else begin
                            pause_cnt_nxt_s = pause_cnt_r + 3'd1;
                        end
                    end
                    default: next_state_s = IDLE;
                endcase
            end
        end else if (state_r != IDLE) begin
            if (tmo_cnt_r == TMO_LAST_C) begin
                next_state_s    = IDLE;
                tmo_cnt_nxt_s   = 22'd0;
                pause_cnt_nxt_s = 3'd0;
            end else begin
                tmo_cnt_nxt_s = tmo_cnt_r + 22'd1;
            end
        end else begin
            tmo_cnt_nxt_s = 22'd0;
        end
    end

    // Event qualification, including the optional auto-repeat filter.
    always_comb begin
        ev_mask_s = key_mask(ev_ext_s, ev_code_s);
`ifdef TYPEMATIC_FILTER_EN
        suppress_s = !ev_brk_s && ((ev_mask_s & key_held_r) != 4'd0);
`else
        suppress_s = 1'b0;
`endif
        valid_s = emit_s && !suppress_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r        <= IDLE;
            pause_cnt_r    <= 3'd0;
            tmo_cnt_r      <= 22'd0;
            key_code_r     <= 8'h00;
            key_extended_r <= 1'b0;
            key_break_r    <= 1'b0;
            key_valid_r    <= 1'b0;
            key_held_r     <= 4'b0000;
        end else begin
            state_r     <= next_state_s;
            pause_cnt_r <= pause_cnt_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            key_valid_r <= valid_s;
            if (valid_s) begin
                key_code_r     <= ev_code_s;
                key_extended_r <= ev_ext_s;
                key_break_r    <= ev_brk_s;
            end
            if (clr_held_s) begin
                key_held_r <= 4'b0000;
            end else if (valid_s && ev_brk_s) begin
                key_held_r <= key_held_r & ~ev_mask_s;
            end else if (valid_s) begin
                key_held_r <= key_held_r | ev_mask_s;
            end
        end
    end

    assign key_code     = key_code_r;
    assign key_extended = key_extended_r;
    assign key_break    = key_break_r;
    assign key_valid    = key_valid_r;
    assign key_held     = key_held_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

    logic       CLOCK_50;
    logic       reset;
    logic [7:0] received_data;
    logic       received_data_en;
    logic [7:0] key_code;
    logic       key_extended, key_break, key_valid;
    logic [3:0] key_held;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [3:0] held;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .key_code         (key_code),
        .key_extended     (key_extended),
        .key_break        (key_break),
        .key_valid        (key_valid),
        .key_held         (key_held)
    );

    // Free-running clock.
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Cycle stamp used to check event latency.
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Strobe one byte that completes no event.
    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    // Strobe the final byte of a sequence and queue the event it must produce.
    task automatic send_ev(input logic [7:0] b, input logic [7:0] code, input logic ext,
                           input logic brk, input logic [3:0] held);
        exp_t e;
        @(negedge CLOCK_50);
        e.code = code; e.ext = ext; e.brk = brk; e.held = held; e.cyc = cyc + 1;
        exp_q.push_back(e);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
    endtask

    // Scoreboard monitor: every key_valid pulse must match the oldest queued event.
    always @(negedge CLOCK_50) begin
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_pulse: key_valid=1 code %0h ext %0b brk %0b, no event required",
                         key_code, key_extended, key_break);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ev_code", 32'(key_code), 32'(e.code));
                check("ev_ext",  32'(key_extended), 32'(e.ext));
                check("ev_brk",  32'(key_break), 32'(e.brk));
                check("ev_held", 32'(key_held), 32'(e.held));
                check("ev_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_code"},  32'(key_code), 32'h00);
        check({tag, "_ext"},   32'(key_extended), 32'h0);
        check({tag, "_brk"},   32'(key_break), 32'h0);
        check({tag, "_valid"}, 32'(key_valid), 32'h0);
        check({tag, "_held"},  32'(key_held), 32'h0);
    endtask

    initial begin
        reset            = 1'b1;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        check_all_zero("reset");

        // Space make, then release.
        send_ev(8'h29, 8'h29, 1'b0, 1'b0, 4'b0001);
        send(8'hF0);
        send_ev(8'h29, 8'h29, 1'b0, 1'b1, 4'b0000);

        // Down: extended make then extended break.
        send(8'hE0);
        send_ev(8'h72, 8'h72, 1'b1, 1'b0, 4'b1000);
        send(8'hE0);
        send(8'hF0);
        send_ev(8'h72, 8'h72, 1'b1, 1'b1, 4'b0000);

        // Outputs hold between events.
        repeat (3) @(negedge CLOCK_50);
        check("hold_code", 32'(key_code), 32'h72);
        check("hold_ext",  32'(key_extended), 32'h1);
        check("hold_brk",  32'(key_break), 32'h1);

        // Pause sequence: a single E1 event after the eighth byte.
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        send_ev(8'h77, 8'hE1, 1'b0, 1'b0, 4'b0000);
        send_ev(8'h16, 8'h16, 1'b0, 1'b0, 4'b0000);

        // Acknowledge byte ignored in IDLE.
        send(8'hFA);
        send_ev(8'h1C, 8'h1C, 1'b0, 1'b0, 4'b0000);

        // Up make; a non-extended 75 release leaves it held.
        send(8'hE0);
        send_ev(8'h75, 8'h75, 1'b1, 1'b0, 4'b0100);
        send(8'hF0);
        send_ev(8'h75, 8'h75, 1'b0, 1'b1, 4'b0100);
        send(8'hE0); send(8'hF0);
        send_ev(8'h75, 8'h75, 1'b1, 1'b1, 4'b0000);

        // Timeout drops a stale E0 prefix.
        send(8'hE0);
        repeat (20) @(negedge CLOCK_50);
        send_ev(8'h75, 8'h75, 1'b0, 1'b0, 4'b0000);

        // Typematic repeats of Enter.
        send_ev(8'h5A, 8'h5A, 1'b0, 1'b0, 4'b0010);
`ifdef TYPEMATIC_FILTER_EN
        send(8'h5A);
        send(8'h5A);
`else
        send_ev(8'h5A, 8'h5A, 1'b0, 1'b0, 4'b0010);
        send_ev(8'h5A, 8'h5A, 1'b0, 1'b0, 4'b0010);
`endif
        repeat (2) @(negedge CLOCK_50);
        check("typematic_held", 32'(key_held), 32'h2);

        // AA mid-sequence clears key_held and returns to IDLE.
        send(8'hE0);
        send(8'hAA);
        repeat (2) @(negedge CLOCK_50);
        check("aa_held_clear", 32'(key_held), 32'h0);
        send_ev(8'h29, 8'h29, 1'b0, 1'b0, 4'b0001);

        // Reset beats a simultaneous strobe while in BRK.
        send(8'hF0);
        @(negedge CLOCK_50);
        received_data    = 8'h29;
        received_data_en = 1'b1;
        reset            = 1'b1;
        @(negedge CLOCK_50);
        received_data_en = 1'b0;
        reset            = 1'b0;
        check_all_zero("reset_strobe");
        @(negedge CLOCK_50);
        check("reset_strobe_nopulse", 32'(key_valid), 32'h0);
        send_ev(8'h29, 8'h29, 1'b0, 1'b0, 4'b0001);

        repeat (5) @(negedge CLOCK_50);
        check("missing_pulses", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
